// File: rtl/isqrt_seq_pkg.sv
// Shared definitions for the sequential integer square root:
// FSM state encodings and the iteration-counter width helper.
package isqrt_seq_pkg;

  // FSM state encodings (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of the iteration counter. The counter only has to hold
  // BITWIDTH-1, so $clog2(BITWIDTH) bits suffice (never narrower than 1).
  function automatic int cnt_width(input int bitwidth);
    return (bitwidth > 1) ? $clog2(bitwidth) : 1;
  endfunction

endpackage

// File: rtl/isqrt_seq_step.sv
// One restoring square-root digit step: brings down two radicand bits,
// tries to subtract (4*root + 1) and produces one new root bit.
// Kept combinational and stand-alone so the step can later be unrolled
// or pipelined without touching the control logic.
module isqrt_step #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH+1:0] rem_p,
  input  logic [BITWIDTH-1:0] root_p,
  input  logic [1:0]          bits,
  output logic [BITWIDTH+1:0] rem_next,
  output logic [BITWIDTH-1:0] root_next
);

  logic [BITWIDTH+1:0] r2;
  logic [BITWIDTH+1:0] t;

  // Trial subtraction: keep the difference when it does not go negative.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path; assigning defaults first makes that obvious and rules out latches.
    rem_next  = '0;
    root_next = '0;
    // The partial remainder never exceeds 2*root_p, so shifting it left by
    // two cannot lose significant bits at BITWIDTH+2 bits.
    r2 = (rem_p << 2) | {{BITWIDTH{1'b0}}, bits};
    t  = {root_p, 2'b01};
    if (r2 >= t) begin
      rem_next  = r2 - t;
      root_next = (root_p << 1) | BITWIDTH'(1);
    end else begin
      rem_next  = r2;
      root_next = root_p << 1;
    end
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root, one result bit per clock.
// Accepts a 2*BITWIDTH-bit radicand over a valid/ready handshake and
// returns floor(sqrt(x)), the remainder x - root^2 and a perfect-square flag.
// The final iteration lands in DONE; the result registers are loaded on
// the first DONE cycle, so out_valid rises BITWIDTH+1 edges after accept.
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*BITWIDTH-1:0] x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITWIDTH-1:0]   root,
  output logic [BITWIDTH:0]     rem,
  output logic                  is_square
);

  localparam int CW = cnt_width(BITWIDTH);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [2*BITWIDTH-1:0] opnd;
  logic [BITWIDTH-1:0]   root_p;
  logic [BITWIDTH+1:0]   rem_p;

  logic [BITWIDTH-1:0]   root_next;
  logic [BITWIDTH+1:0]   rem_next;

  isqrt_step #(
    .BITWIDTH (BITWIDTH)
  ) u_step (
    .rem_p     (rem_p),
    .root_p    (root_p),
    .bits      (opnd[2*BITWIDTH-1 -: 2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // Control FSM, iteration datapath and registered result/handshake outputs.
  always_ff @(posedge sys_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // in this block samples the values from before the clock edge.
    if (sys_rst) begin
      // Datapath registers are cleared as well; an aborted operation
      // leaves nothing behind that could leak into the next one.
      state     <= ST_IDLE;
      cnt       <= '0;
      opnd      <= '0;
      root_p    <= '0;
      rem_p     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      root      <= '0;
      rem       <= '0;
      is_square <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            opnd     <= x;
            root_p   <= '0;
            rem_p    <= '0;
            cnt      <= CW'(BITWIDTH - 1);
            in_ready <= 1'b0;
            state    <= ST_CALC;
          end
        end

        ST_CALC: begin
          opnd   <= opnd << 2;
          root_p <= root_next;
          rem_p  <= rem_next;
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_DONE: begin
          if (!out_valid) begin
            // Publish the finished result; it stays put under backpressure.
            out_valid <= 1'b1;
            root      <= root_p;
            rem       <= rem_p[BITWIDTH:0];
            is_square <= (rem_p == '0);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed boundary cases plus random
// operands on a 32-bit and an 8-bit instance, checked by scoreboards
// against a binary-search square-root model.
module tb_isqrt_seq;

  typedef struct {
    logic [63:0] x;
    logic [31:0] root;
    logic [32:0] rem;
    logic        sq;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] root;
  logic [32:0] rem;
  logic        is_square;

  // 8-bit instance
  logic        rst8;
  logic        in_valid8;
  logic        in_ready8;
  logic [15:0] x8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  root8;
  logic [8:0]  rem8;
  logic        is_square8;

  isqrt_seq #(.BITWIDTH(32)) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem),
    .is_square (is_square)
  );

  isqrt_seq #(.BITWIDTH(8)) dut8 (
    .sys_clk   (clk),
    .sys_rst   (rst8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .x         (x8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .root      (root8),
    .rem       (rem8),
    .is_square (is_square8)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;
  bit   rand_bp  = 0;
  bit   rand_bp8 = 0;
  bit   done8    = 0;
  exp_t sb[$];
  exp_t q8[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor(sqrt(v)) by binary search on plain integers.
  function automatic logic [31:0] ref_root(input logic [63:0] v);
    logic [32:0] lo, hi, mid;
    logic [65:0] sq;
    lo = '0;
    hi = 33'h1_0000_0000;
    while (hi - lo > 33'd1) begin
      mid = (lo + hi) >> 1;
      sq  = 66'(mid) * 66'(mid);
      if (sq <= 66'(v)) lo = mid;
      else              hi = mid;
    end
    return lo[31:0];
  endfunction

  function automatic logic [32:0] ref_rem(input logic [63:0] v, input logic [31:0] r);
    logic [63:0] sq;
    sq = 64'(r) * 64'(r);
    return 33'(v - sq);
  endfunction

  // Random backpressure generators.
  always @(posedge clk) begin
    #1;
    if (rand_bp)  out_ready  = 1'($urandom_range(0, 1));
    if (rand_bp8) out_ready8 = 1'($urandom_range(0, 1));
  end

  // ---------------- 32-bit monitor ----------------
  exp_t        mon_e;
  logic        hold_v = 1'b0;
  logic [31:0] hold_root;
  logic [32:0] hold_rem;
  logic        hold_sq;

  always @(negedge clk) begin
    if (out_valid && hold_v) begin
      check("hold_root", root, hold_root);
      check("hold_rem", rem, hold_rem);
      check("hold_sq", is_square, hold_sq);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("root", root, mon_e.root);
        check("rem", rem, mon_e.rem);
        check("is_square", is_square, mon_e.sq);
        check("identity", 128'(64'(root) * 64'(root)) + 128'(rem), 128'(mon_e.x));
        check("rem_bound", (rem <= 2 * 33'(root)), 1'b1);
      end
    end
    hold_v    = out_valid && !out_ready;
    hold_root = root;
    hold_rem  = rem;
    hold_sq   = is_square;
  end

  // ---------------- 8-bit monitor ----------------
  exp_t mon8_e;
  always @(negedge clk) begin
    if (out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        check("unexpected_output8", out_valid8, 1'b0);
      end else begin
        mon8_e = q8.pop_front();
        check("root8", root8, mon8_e.root[7:0]);
        check("rem8", rem8, mon8_e.rem[8:0]);
        check("is_square8", is_square8, mon8_e.sq);
        check("identity8", 32'(16'(root8) * 16'(root8)) + 32'(rem8), 32'(mon8_e.x));
      end
    end
  end

  // Issue one operand; the expected result is queued before the accept edge.
  task automatic send(input logic [63:0] v, input logic [31:0] er, input logic [32:0] erem);
    exp_t e;
    int   waited;
    @(posedge clk); #1;
    in_valid = 1'b1;
    x        = v;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    e.x = v; e.root = er; e.rem = erem; e.sq = (erem == '0);
    sb.push_back(e);
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
    x          = {$urandom, $urandom};
  endtask

  task automatic send_model(input logic [63:0] v);
    logic [31:0] r;
    r = ref_root(v);
    send(v, r, ref_rem(v, r));
  endtask

  task automatic send8(input logic [15:0] v, input logic [7:0] er, input logic [8:0] erem);
    exp_t e;
    int   waited;
    @(posedge clk); #1;
    in_valid8 = 1'b1;
    x8        = v;
    waited    = 0;
    @(negedge clk);
    while (!in_ready8 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready8) begin
      check("send8_timeout", in_ready8, 1'b1);
      in_valid8 = 1'b0;
      return;
    end
    e.x = 64'(v); e.root = 32'(er); e.rem = 33'(erem); e.sq = (erem == '0);
    q8.push_back(e);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    x8        = 16'($urandom);
  endtask

  task automatic drain32();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain32", sb.size(), 0);
  endtask

  // ---------------- 8-bit stimulus ----------------
  initial begin : stim8
    logic [7:0]  r;
    logic [15:0] v;
    logic [31:0] rr;
    rst8 = 1'b1; in_valid8 = 1'b0; x8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b0;
    send8(16'h0000, 8'h00, 9'h000);
    send8(16'hFFFF, 8'hFF, 9'h1FE);
    rand_bp8 = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        r = 8'($urandom);
        send8(16'(r) * 16'(r), r, 9'h000);
      end else begin
        v  = 16'($urandom);
        rr = ref_root(64'(v));
        send8(v, rr[7:0], 9'(ref_rem(64'(v), rr)));
      end
    end
    rand_bp8 = 0;
    @(posedge clk); #1 out_ready8 = 1'b1;
    done8 = 1;
  end

  // ---------------- 32-bit stimulus ----------------
  initial begin : main
    int          lat, low, n;
    bit          seen_ov;
    logic [31:0] r;
    logic [63:0] v;
    sys_rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1 sys_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_root", root, 32'h0);
    check("post_rst_rem", rem, 33'h0);
    check("post_rst_sq", is_square, 1'b0);

    // x=144: latency and busy window; in_valid held high while busy.
    send(64'd144, 32'd12, 33'd0);
    in_valid = 1'b1;
    x        = 64'd7;
    lat = -1; low = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid && lat < 0) lat = cyc - accept_cyc;
      if (in_ready) begin
        in_valid = 1'b0;
        low      = cyc - accept_cyc;
        break;
      end
    end
    in_valid = 1'b0;
    check("latency_144", 32'(lat), 32'd33);
    check("in_ready_low_144", 32'(low), 32'd34);

    // Back-to-back, all-ones boundary.
    send(64'd145, 32'd12, 33'd1);
    send(64'd0, 32'd0, 33'd0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    drain32();

    // Backpressure: result held for 20 cycles, released one cycle later.
    @(posedge clk); #1 out_ready = 1'b0;
    send(64'd1000000000000000000, 32'd1000000000, 33'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", out_valid, 1'b1);
    repeat (20) @(negedge clk);
    check("bp_still_valid", out_valid, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", out_valid, 1'b0);

    // Reset during CALC aborts the operation.
    send(64'd99, 32'd9, 33'd18);
    repeat (10) @(posedge clk);
    #1 sys_rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 sys_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b1);
    seen_ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_ov = 1;
    end
    check("abort_no_output", seen_ov, 1'b0);
    send(64'd99, 32'd9, 33'd18);
    drain32();

    // Random operands with random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: send_model({$urandom, $urandom});
        1: begin
          r = $urandom;
          send(64'(r) * 64'(r), r, 33'd0);
        end
        2: begin
          r = $urandom;
          v = 64'(r) * 64'(r) + 64'($urandom_range(0, 3));
          send_model(v);
        end
        default: send_model(64'($urandom_range(0, 1000)));
      endcase
    end
    rand_bp = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain32();

    n = 0;
    while ((!done8 || q8.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain8", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
